// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bundle between operand fetch, alu_seq and writeback
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carryout;
    logic             overflow;
    logic             divzero;
    logic             busy;

    // ALU side
    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, result, zero, negative, carryout, overflow, divzero, busy
    );

    // requester / consumer side
    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, result, zero, negative, carryout, overflow, divzero, busy
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered, handshaked ALU with iterative signed divide/modulo
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    alu_seq_if.slave    bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_NAND = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_MOD  = 4'b1011;
    localparam logic [3:0] OP_SLL  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1110;
    localparam logic [3:0] OP_SRL  = 4'b1111;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FIX    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // output register
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_negative, r_carryout, r_overflow, r_divzero;

    // divider state
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [SHW-1:0]   r_cnt;
    logic             r_is_mod, r_neg_q, r_neg_r, r_div_ovf;

    // handshake / control
    logic w_in_ready, w_busy, w_fix_load;
    logic w_accept, w_is_div, w_b_zero, w_start_div, w_load_single;

    assign w_is_div      = (bus.opcode == OP_DIV) || (bus.opcode == OP_MOD);
    assign w_b_zero      = (bus.b == '0);
    assign w_accept      = bus.in_valid && w_in_ready;
    // divide by zero bypasses the iterative path and completes like a single-cycle op
    assign w_start_div   = w_accept && w_is_div && !w_b_zero;
    assign w_load_single = w_accept && !w_start_div;

    // single-cycle datapath
    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_cy, w_ov, w_dz;

    assign w_sh   = bus.b[SHW-1:0];
    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

    // result and flags for every opcode that completes at the accept edge
    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        w_ov  = 1'b0;
        w_dz  = 1'b0;
        case (bus.opcode)
            OP_AND:  w_res = bus.a & bus.b;
            OP_OR:   w_res = bus.a | bus.b;
            OP_XOR:  w_res = bus.a ^ bus.b;
            OP_NOR:  w_res = ~(bus.a | bus.b);
            OP_NAND: w_res = ~(bus.a & bus.b);
            OP_NOT:  w_res = ~bus.a;
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cy  = w_sum[WIDTH];
                w_ov  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_cy  = w_diff[WIDTH];
                w_ov  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_MUL:  w_res = bus.a * bus.b;
            OP_DIV,
            OP_MOD:  w_dz  = w_b_zero;
            OP_SLL:  w_res = bus.a << w_sh;
            OP_SRA:  w_res = $unsigned($signed(bus.a) >>> w_sh);
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SRL:  w_res = bus.a >> w_sh;
            default: w_res = '0;
        endcase
    end

    // restoring divider on magnitudes; |MIN_NEG| fits as an unsigned WIDTH value
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_rem_sh, w_trial;
    logic             w_fit;
    logic [WIDTH-1:0] w_q_fix, w_r_fix, w_fix_res;

    assign w_a_mag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign w_b_mag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_dvs};
    assign w_fit     = !w_trial[WIDTH];
    assign w_q_fix   = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix   = r_neg_r ? -r_rem : r_rem;
    assign w_fix_res = r_is_mod ? w_r_fix : w_q_fix;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_div) w_next = S_DIVIDE;
            S_DIVIDE: if (r_cnt == CNT_LAST) w_next = S_FIX;
            S_FIX:    if (!r_out_valid || bus.out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // FSM-decoded control outputs
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b1;
        w_fix_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = !r_out_valid || bus.out_ready;
                w_busy     = 1'b0;
            end
            S_FIX:   w_fix_load = !r_out_valid || bus.out_ready;
            default: ;
        endcase
    end

    // divider operand capture and one quotient bit per DIVIDE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_cnt     <= '0;
            r_is_mod  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div_ovf <= 1'b0;
        end else if (w_start_div) begin
            r_quo     <= w_a_mag;
            r_rem     <= '0;
            r_dvs     <= w_b_mag;
            r_cnt     <= '0;
            r_is_mod  <= (bus.opcode == OP_MOD);
            r_neg_q   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_neg_r   <= bus.a[WIDTH-1];
            r_div_ovf <= (bus.opcode == OP_DIV) && (bus.a == MIN_NEG) && (bus.b == '1);
        end else if (r_state == S_DIVIDE) begin
            r_rem <= w_fit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fit};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // one-deep output register: load, hold under back-pressure, or drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_carryout  <= 1'b0;
            r_overflow  <= 1'b0;
            r_divzero   <= 1'b0;
        end else if (w_load_single) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_zero      <= (w_res == '0);
            r_negative  <= w_res[WIDTH-1];
            r_carryout  <= w_cy;
            r_overflow  <= w_ov;
            r_divzero   <= w_dz;
        end else if (w_fix_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_fix_res;
            r_zero      <= (w_fix_res == '0);
            r_negative  <= w_fix_res[WIDTH-1];
            r_carryout  <= 1'b0;
            r_overflow  <= r_div_ovf;
            r_divzero   <= 1'b0;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.negative  = r_negative;
    assign bus.carryout  = r_carryout;
    assign bus.overflow  = r_overflow;
    assign bus.divzero   = r_divzero;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH 32 and 8
module tb_alu_seq;
    localparam logic [3:0] OP_AND  = 4'b0000, OP_OR  = 4'b0001, OP_XOR  = 4'b0010, OP_NOR = 4'b0011;
    localparam logic [3:0] OP_NAND = 4'b0100, OP_NOT = 4'b0101, OP_ADD  = 4'b0110, OP_SUB = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000, OP_MUL = 4'b1001, OP_DIV  = 4'b1010, OP_MOD = 4'b1011;
    localparam logic [3:0] OP_SLL  = 4'b1100, OP_SRA = 4'b1101, OP_SLTU = 4'b1110, OP_SRL = 4'b1111;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus32();
    alu_seq_if #(.WIDTH(8))  bus8();

    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    // {out_valid, zero, negative, carryout, overflow, divzero}
    function automatic logic [5:0] flags32();
        return {bus32.out_valid, bus32.zero, bus32.negative, bus32.carryout, bus32.overflow, bus32.divzero};
    endfunction

    function automatic logic [5:0] flags8();
        return {bus8.out_valid, bus8.zero, bus8.negative, bus8.carryout, bus8.overflow, bus8.divzero};
    endfunction

    task automatic issue32(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus32.opcode = op; bus32.a = x; bus32.b = y; bus32.in_valid = 1'b1;
        @(negedge clk);
        bus32.in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        bus8.opcode = op; bus8.a = x; bus8.b = y; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    // counts edges after the accept edge until out_valid, noting any cycle not stalled
    task automatic wait_result32(output int lat, output int not_stalled);
        lat = 0;
        not_stalled = 0;
        while (bus32.out_valid !== 1'b1 && lat < 100) begin
            if (bus32.in_ready !== 1'b0 || bus32.busy !== 1'b1) not_stalled++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #3 reset = 1'b1;
        #1;
        total++; if (bus32.result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", bus32.result); end
        total++; if (flags32() !== 6'b0) begin bad++; $display("FAIL reset_flags: got %b want 000000", flags32()); end
        total++; if (bus32.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus32.busy); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus32.in_ready); end
    endtask

    task automatic test_add_overflow;
        issue32(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        total++; if (bus32.result !== 32'h8000_0000) begin bad++; $display("FAIL add_ovf_result: got %h want 80000000", bus32.result); end
        total++; if (flags32() !== 6'b101010) begin bad++; $display("FAIL add_ovf_flags: got %b want 101010", flags32()); end
    endtask

    task automatic test_sub;
        issue32(OP_SUB, 32'd3, 32'd5);
        total++; if (bus32.result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_borrow_result: got %h want fffffffe", bus32.result); end
        total++; if (flags32() !== 6'b101100) begin bad++; $display("FAIL sub_borrow_flags: got %b want 101100", flags32()); end
        issue32(OP_SUB, 32'd5, 32'd5);
        total++; if (bus32.result !== 32'h0) begin bad++; $display("FAIL sub_zero_result: got %h want 0", bus32.result); end
        total++; if (flags32() !== 6'b110000) begin bad++; $display("FAIL sub_zero_flags: got %b want 110000", flags32()); end
    endtask

    task automatic test_logic_table;
        logic [3:0]  ops [12] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_NOT,
                                  OP_MUL, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA};
        logic [31:0] av  [12] = '{32'hF0, 32'hF0, 32'hFF, 32'h0, 32'hFFFF_FFFF, 32'h0F0F_0F0F,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv  [12] = '{32'h3C, 32'h0F, 32'h0F, 32'h0, 32'hFFFF_FFFF, 32'h0,
                                  32'h5, 32'h1, 32'h1, 32'd31, 32'd4, 32'd4};
        logic [31:0] ev  [12] = '{32'h30, 32'hFF, 32'hF0, 32'hFFFF_FFFF, 32'h0, 32'hF0F0_F0F0,
                                  32'hFFFF_FFF1, 32'h1, 32'h0, 32'h8000_0000, 32'h0800_0000, 32'hF800_0000};
        logic [5:0]  ef;
        for (int i = 0; i < 12; i++) begin
            issue32(ops[i], av[i], bv[i]);
            ef = {1'b1, (ev[i] == 32'h0), ev[i][31], 3'b000};
            total++; if (bus32.result !== ev[i]) begin bad++; $display("FAIL table_result[%0d]: got %h want %h", i, bus32.result, ev[i]); end
            total++; if (flags32() !== ef) begin bad++; $display("FAIL table_flags[%0d]: got %b want %b", i, flags32(), ef); end
        end
    endtask

    task automatic test_divide;
        logic [3:0]  ops [4] = '{OP_DIV, OP_MOD, OP_DIV, OP_MOD};
        logic [31:0] av  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv  [4] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
        logic [5:0]  ef  [4] = '{6'b101000, 6'b101000, 6'b101010, 6'b110000};
        int lat, ns;
        for (int i = 0; i < 4; i++) begin
            issue32(ops[i], av[i], bv[i]);
            wait_result32(lat, ns);
            total++; if (lat !== 33) begin bad++; $display("FAIL div_latency[%0d]: got %0d want 33", i, lat); end
            total++; if (ns !== 0) begin bad++; $display("FAIL div_stall[%0d]: got %0d unstalled cycles want 0", i, ns); end
            total++; if (bus32.result !== ev[i]) begin bad++; $display("FAIL div_result[%0d]: got %h want %h", i, bus32.result, ev[i]); end
            total++; if (flags32() !== ef[i]) begin bad++; $display("FAIL div_flags[%0d]: got %b want %b", i, flags32(), ef[i]); end
        end
    endtask

    task automatic test_divzero;
        logic [3:0] ops [2] = '{OP_DIV, OP_MOD};
        int lat, ns;
        for (int i = 0; i < 2; i++) begin
            issue32(ops[i], 32'd9, 32'd0);
            wait_result32(lat, ns);
            total++; if (lat !== 0) begin bad++; $display("FAIL divzero_latency[%0d]: got %0d extra edges want 0", i, lat); end
            total++; if (bus32.result !== 32'h0) begin bad++; $display("FAIL divzero_result[%0d]: got %h want 0", i, bus32.result); end
            total++; if (flags32() !== 6'b110001) begin bad++; $display("FAIL divzero_flags[%0d]: got %b want 110001", i, flags32()); end
        end
    endtask

    task automatic test_back_pressure;
        @(negedge clk);
        bus32.out_ready = 1'b0;
        bus32.opcode = OP_ADD; bus32.a = 32'd2; bus32.b = 32'd3; bus32.in_valid = 1'b1;
        @(negedge clk);
        bus32.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus32.result !== 32'd5) begin bad++; $display("FAIL bp_hold_result[%0d]: got %h want 5", i, bus32.result); end
            total++; if (flags32() !== 6'b100000) begin bad++; $display("FAIL bp_hold_flags[%0d]: got %b want 100000", i, flags32()); end
            total++; if (bus32.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus32.in_ready); end
            @(negedge clk);
        end
        bus32.out_ready = 1'b1;
        bus32.a = 32'd10; bus32.b = 32'd20; bus32.in_valid = 1'b1;
        #1;
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_ready: got %b want 1", bus32.in_ready); end
        @(negedge clk);
        bus32.in_valid = 1'b0;
        total++; if (bus32.result !== 32'd30) begin bad++; $display("FAIL bp_second_result: got %h want 1e", bus32.result); end
        total++; if (flags32() !== 6'b100000) begin bad++; $display("FAIL bp_second_flags: got %b want 100000", flags32()); end
    endtask

    task automatic test_shift8;
        issue8(OP_SRA, 8'h90, 8'd3);
        total++; if (bus8.result !== 8'hF2) begin bad++; $display("FAIL sra8_result: got %h want f2", bus8.result); end
        total++; if (flags8() !== 6'b101000) begin bad++; $display("FAIL sra8_flags: got %b want 101000", flags8()); end
        issue8(OP_SRL, 8'h90, 8'd3);
        total++; if (bus8.result !== 8'h12) begin bad++; $display("FAIL srl8_result: got %h want 12", bus8.result); end
        total++; if (flags8() !== 6'b100000) begin bad++; $display("FAIL srl8_flags: got %b want 100000", flags8()); end
    endtask

    task automatic test_reset_mid_divide;
        int stray;
        issue32(OP_DIV, 32'd100, 32'd3);
        repeat (10) @(negedge clk);
        total++; if (bus32.busy !== 1'b1) begin bad++; $display("FAIL mid_div_busy: got %b want 1", bus32.busy); end
        #2 reset = 1'b1;
        #1;
        total++; if (bus32.result !== 32'h0) begin bad++; $display("FAIL abort_result: got %h want 0", bus32.result); end
        total++; if (flags32() !== 6'b0) begin bad++; $display("FAIL abort_flags: got %b want 000000", flags32()); end
        total++; if (bus32.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", bus32.busy); end
        @(negedge clk); reset = 1'b0;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus32.out_valid !== 1'b0) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL abort_stray_valid: got %0d cycles want 0", stray); end
        issue32(OP_AND, 32'hF0, 32'h3C);
        total++; if (bus32.result !== 32'h30) begin bad++; $display("FAIL post_abort_result: got %h want 30", bus32.result); end
        total++; if (flags32() !== 6'b100000) begin bad++; $display("FAIL post_abort_flags: got %b want 100000", flags32()); end
    endtask

    initial begin
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.opcode = '0; bus32.out_ready = 1'b1;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.opcode  = '0; bus8.out_ready  = 1'b1;
        test_reset();
        test_add_overflow();
        test_sub();
        test_logic_table();
        test_divide();
        test_divzero();
        test_back_pressure();
        test_shift8();
        test_reset_mid_divide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
